// File: rtl/pe_part_sum_accum_fsm_if.sv
// Network-side and activation-side signals of the partial-sum accumulator.
// master = the driver of start/recv_* (PE controller and network), slave = the accumulator.
interface pe_part_sum_accum_fsm_if #(
  parameter int DATA_WIDTH = 16,
  parameter int RANK_WIDTH = 4,
  parameter int SRC_WIDTH  = 8
);
  logic                  start;
  logic [RANK_WIDTH:0]   rank_no;
  logic [SRC_WIDTH-1:0]  num_src;
  // A beat transfers on a cycle where recv_en && recv_rdy at the rising clock edge;
  // recv_rdy depends only on state, never on recv_en, so there is no combinational loop.
  logic                  recv_en;
  logic [RANK_WIDTH:0]   recv_addr;
  logic [DATA_WIDTH-1:0] recv_data;
  logic                  recv_rdy;
  logic                  act_write_en;
  logic [RANK_WIDTH-1:0] act_write_addr;
  logic [DATA_WIDTH-1:0] act_write_data;
  logic                  busy;
  logic                  fin_accum;
  logic                  err_addr;
  logic [1:0]            dbg_state;

  modport master (
    output start, rank_no, num_src, recv_en, recv_addr, recv_data,
    input  recv_rdy, act_write_en, act_write_addr, act_write_data,
           busy, fin_accum, err_addr, dbg_state
  );

  modport slave (
    input  start, rank_no, num_src, recv_en, recv_addr, recv_data,
    output recv_rdy, act_write_en, act_write_addr, act_write_data,
           busy, fin_accum, err_addr, dbg_state
  );
endinterface

// File: rtl/pe_part_sum_accum_fsm.sv
// Collects broadcast partial sums per rank index, then writes saturated totals
// into the activation register file and pulses fin_accum.
module pe_part_sum_accum_fsm #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int RANK_WIDTH = 4,
  parameter int SRC_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  pe_part_sum_accum_fsm_if.slave bus
);
  localparam int DEPTH = 1 << RANK_WIDTH;
  localparam int CW    = RANK_WIDTH + 1 + SRC_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WRITEBACK = 2'd2
  } state_t;

  state_t                       state_q;
  logic [RANK_WIDTH:0]          rank_q;
  logic [SRC_WIDTH-1:0]         src_q;
  logic signed [ACC_WIDTH-1:0]  acc_q [DEPTH];
  logic [CW-1:0]                cnt_q;
  logic [RANK_WIDTH-1:0]        wb_idx_q;
  logic                         err_q;
  logic                         fin_q;

  logic [CW-1:0]                exp_beats;
  logic [CW-1:0]                cnt_d;
  logic                         beat_fire;
  logic                         addr_ok;
  logic                         wb_last;
  logic signed [ACC_WIDTH-1:0]  wb_acc;
  logic signed [ACC_WIDTH-1:0]  beat_ext;
  logic [DATA_WIDTH-1:0]        wb_sat;

  always_comb begin
    exp_beats = CW'(rank_q) * CW'(src_q);
    cnt_d     = cnt_q + CW'(1);
    beat_fire = bus.recv_en && (state_q == COLLECT);
    addr_ok   = (bus.recv_addr < rank_q);
    wb_last   = ({1'b0, wb_idx_q} == (rank_q - 1'b1));
    beat_ext  = {{(ACC_WIDTH-DATA_WIDTH){bus.recv_data[DATA_WIDTH-1]}}, bus.recv_data};
    wb_acc    = acc_q[wb_idx_q];
    wb_sat    = wb_acc[DATA_WIDTH-1:0];
    if (wb_acc > SAT_MAX) begin
      wb_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (wb_acc < SAT_MIN) begin
      wb_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  assign bus.recv_rdy       = (state_q == COLLECT);
  assign bus.busy           = (state_q != IDLE);
  assign bus.act_write_en   = (state_q == WRITEBACK);
  assign bus.act_write_addr = wb_idx_q;
  assign bus.act_write_data = wb_sat;
  // fin_q covers the empty round; the writeback case coincides with the last write.
  assign bus.fin_accum      = fin_q || ((state_q == WRITEBACK) && wb_last);
  assign bus.err_addr       = err_q;
  assign bus.dbg_state      = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rank_q   <= '0;
      src_q    <= '0;
      cnt_q    <= '0;
      wb_idx_q <= '0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
    end else begin
      fin_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rank_q <= bus.rank_no;
            src_q  <= bus.num_src;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
            if ((bus.rank_no == '0) || (bus.num_src == '0)) begin
              fin_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (beat_fire) begin
            cnt_q <= cnt_d;
            if (addr_ok) begin
              acc_q[bus.recv_addr[RANK_WIDTH-1:0]] <=
                acc_q[bus.recv_addr[RANK_WIDTH-1:0]] + beat_ext;
            end else begin
              err_q <= 1'b1;
            end
            if (cnt_d == exp_beats) begin
              state_q  <= WRITEBACK;
              wb_idx_q <= '0;
            end
          end
        end
        WRITEBACK: begin
          wb_idx_q <= wb_idx_q + 1'b1;
          if (wb_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_part_sum_accum_fsm.sv
// Randomised and directed bench for pe_part_sum_accum_fsm with a write scoreboard.
module tb_pe_part_sum_accum_fsm;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int RW = 4;
  localparam int SW = 8;
  localparam int W  = 1 + RW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_part_sum_accum_fsm_if #(.DATA_WIDTH(DW), .RANK_WIDTH(RW), .SRC_WIDTH(SW)) bus ();

  pe_part_sum_accum_fsm #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .RANK_WIDTH(RW), .SRC_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int beat_addr[$];
  int beat_data[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Monitor: every activation write is compared with the next expected {fin, addr, data}.
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (!rst && bus.act_write_en) begin
      mon_got = {bus.fin_accum, bus.act_write_addr, bus.act_write_data};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got 0x%0h expected no write at %0t", mon_got, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_fin_addr_data", mon_got, mon_exp);
        check("rdy_during_wb", bus.recv_rdy, 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0; bus.rank_no = '0; bus.num_src = '0;
    bus.recv_en = 1'b0; bus.recv_addr = '0; bus.recv_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Reference: per-rank sums of in-range beats, then saturated totals in address order.
  task automatic run_round(input int rank, input int src, input bit hold_en,
                           input int start_mid, input bit gaps);
    int tot[16];
    bit err;
    int n;
    logic [DW-1:0] d;
    err = 1'b0;
    for (int i = 0; i < 16; i++) tot[i] = 0;
    foreach (beat_addr[j]) begin
      if (beat_addr[j] < rank) tot[beat_addr[j]] += beat_data[j];
      else err = 1'b1;
    end
    for (int i = 0; i < rank; i++) begin
      d = DW'(sat(tot[i]));
      exp_q.push_back({(i == rank - 1), RW'(i), d});
    end

    @(negedge clk);
    bus.start = 1'b1; bus.rank_no = (RW+1)'(rank); bus.num_src = SW'(src);
    @(negedge clk);
    bus.start = 1'b0;
    check("rdy_in_collect", bus.recv_rdy, 1);
    check("busy_in_collect", bus.busy, 1);
    foreach (beat_addr[j]) begin
      if (gaps) begin
        bus.recv_en = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      bus.recv_en = 1'b1;
      bus.recv_addr = (RW+1)'(beat_addr[j]);
      bus.recv_data = DW'(beat_data[j]);
      if (j == start_mid) begin
        bus.start = 1'b1; bus.rank_no = '0; bus.num_src = '0;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (hold_en) begin
      bus.recv_addr = '0;
      bus.recv_data = 16'h1234;
    end else begin
      bus.recv_en = 1'b0;
    end
    check("wb_starts_next_cycle", bus.act_write_en, 1);
    check("wb_first_addr", bus.act_write_addr, 0);
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.recv_en = 1'b0;
    check("round_len", n, rank);
    check("err_addr", bus.err_addr, err);
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
    beat_addr.delete();
    beat_data.delete();
  endtask

  task automatic degenerate(input int rank, input int src);
    @(negedge clk);
    bus.start = 1'b1; bus.rank_no = (RW+1)'(rank); bus.num_src = SW'(src);
    @(negedge clk);
    bus.start = 1'b0;
    check("deg_fin_pulse", bus.fin_accum, 1);
    check("deg_busy", bus.busy, 0);
    check("deg_no_write", bus.act_write_en, 0);
    check("deg_err_cleared", bus.err_addr, 0);
    @(negedge clk);
    check("deg_fin_one_cycle", bus.fin_accum, 0);
    check("deg_busy_after", bus.busy, 0);
  endtask

  task automatic add_beat(input int a, input int d);
    beat_addr.push_back(a);
    beat_data.push_back(d);
  endtask

  initial begin
    int rank, src, sm;
    do_reset();
    check("rst_recv_rdy", bus.recv_rdy, 0);
    check("rst_write_en", bus.act_write_en, 0);
    check("rst_write_addr", bus.act_write_addr, 0);
    check("rst_write_data", bus.act_write_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fin", bus.fin_accum, 0);
    check("rst_err", bus.err_addr, 0);

    // Basic accumulation, back to back.
    add_beat(0, 10); add_beat(1, 20); add_beat(2, 30); add_beat(3, 40);
    add_beat(0, 1);  add_beat(1, 2);  add_beat(2, 3);  add_beat(3, 4);
    run_round(4, 2, 1'b0, -1, 1'b0);

    // Positive and negative saturation.
    repeat (3) add_beat(0, 20000);
    run_round(1, 3, 1'b0, -1, 1'b0);
    repeat (3) add_beat(0, -20000);
    run_round(1, 3, 1'b0, -1, 1'b0);

    // Out-of-range address, then a fresh start clears the flag.
    add_beat(3, 5); add_beat(0, 7);
    run_round(2, 1, 1'b0, -1, 1'b0);
    check("err_sticky_after_round", bus.err_addr, 1);
    degenerate(3, 0);
    degenerate(0, 5);

    // Reset in the middle of collection.
    @(negedge clk);
    bus.start = 1'b1; bus.rank_no = 5'd2; bus.num_src = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.recv_en = 1'b1; bus.recv_addr = 5'd0; bus.recv_data = 16'd100;
    @(negedge clk);
    bus.recv_addr = 5'd1; bus.recv_data = 16'd50;
    @(negedge clk);
    bus.recv_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_write_en", bus.act_write_en, 0);
    add_beat(0, 1); add_beat(1, 2);
    run_round(2, 1, 1'b0, -1, 1'b0);

    // recv_en held through writeback, start pulsed mid-collect.
    add_beat(0, 10); add_beat(1, 20); add_beat(2, 30); add_beat(3, 40);
    add_beat(0, 1);  add_beat(1, 2);  add_beat(2, 3);  add_beat(3, 4);
    run_round(4, 2, 1'b1, 3, 1'b0);

    // Random rounds against the reference model.
    for (int r = 0; r < 12; r++) begin
      rank = $urandom_range(1, 16);
      src  = $urandom_range(1, 3);
      for (int b = 0; b < rank * src; b++) begin
        if ($urandom_range(0, 9) == 0) add_beat($urandom_range(rank, 31), $urandom_range(0, 100));
        else add_beat($urandom_range(0, rank - 1), int'($urandom_range(0, 65535)) - 32768);
      end
      sm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rank * src - 1) : -1;
      run_round(rank, src, 1'($urandom_range(0, 1)), sm, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_part_sum_accum_fsm.md
Name: pe_part_sum_accum_fsm

Overview:
- Downstream of the V-stage partial-sum broadcaster in each PE.
- Collects the partial sums that all broadcasting PEs send over the network interface. Each partial sum carries its rank index as the address.
- Accumulates the partial sums per rank index into a local accumulator bank.
- After the expected number of beats has arrived, writes the saturated totals sequentially into the activation register file and pulses a finish flag to the PE controller.

Parameters:
- DATA_WIDTH, 16, signed partial-sum and activation width.
- ACC_WIDTH, 24, signed accumulator width. Must be at least DATA_WIDTH+SRC_WIDTH.
- RANK_WIDTH, 4, rank-index width. Accumulator bank depth is 2^RANK_WIDTH.
- SRC_WIDTH, 8, width of the broadcasting-PE count.

Ports:
- clk  in  1  system clock
- rst  in  1  system reset; synchronous, active-high
- start  in  1  begin a collection round; honoured only in IDLE
- rank_no  in  RANK_WIDTH+1  ranks per source, legal range 0..2^RANK_WIDTH; sampled on start
- num_src  in  SRC_WIDTH  number of broadcasting PEs; sampled on start
- recv_en  in  1  network interface has a partial-sum beat
- recv_addr  in  RANK_WIDTH+1  rank index of the beat
- recv_data  in  DATA_WIDTH  signed partial sum
- recv_rdy  out  1  block accepts beats
- act_write_en  out  1  activation register-file write enable
- act_write_addr  out  RANK_WIDTH  write address
- act_write_data  out  DATA_WIDTH  saturated accumulated value
- busy  out  1  state is not IDLE
- fin_accum  out  1  one-cycle pulse: round complete
- err_addr  out  1  sticky flag: a beat had recv_addr >= latched rank_no

Behaviour:
- Reset: state=IDLE. All accumulators, counters, latched rank_no/num_src, err_addr and fin_accum are 0.
- Outputs recv_rdy, act_write_en, act_write_addr, act_write_data and busy are decoded combinationally from state and registers. After reset they are all 0.
- Expected beat count: EXP = rank_no*num_src, computed from the latched values (RANK_WIDTH+1+SRC_WIDTH bits). Beat counter has the same width.
- IDLE:
  - recv_rdy=0.
  - On start: latch rank_no and num_src, clear every accumulator, clear the beat counter, clear err_addr.
  - If rank_no==0 or num_src==0: stay in IDLE, pulse fin_accum in the next cycle, perform no writes.
  - Otherwise go to COLLECT.
- COLLECT:
  - recv_rdy=1. A beat is accepted when recv_en && recv_rdy.
  - If recv_addr < rank_no: acc[recv_addr] <= acc[recv_addr] + sign_extend(recv_data). Accumulators are updated in a single cycle, so back-to-back beats to the same address accumulate correctly.
  - If recv_addr >= rank_no: data is dropped and err_addr is set.
  - Every accepted beat increments the beat counter, dropped beats included.
  - When an accepted beat brings the counter to EXP, the next state is WRITEBACK and the writeback index is cleared to 0.
  - start is ignored.
- WRITEBACK:
  - recv_rdy=0. recv_en is ignored and beats are not counted.
  - Each cycle: act_write_en=1, act_write_addr=wb_idx, act_write_data=sat(acc[wb_idx]); then wb_idx increments.
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - When wb_idx==rank_no-1: fin_accum=1 in that same cycle, next state IDLE.
  - start is ignored.
- Timing:
  - If the last beat is accepted in cycle t, writes occur in cycles t+1..t+rank_no.
  - fin_accum coincides with the write to address rank_no-1.
  - The next start is honoured at the earliest in cycle t+rank_no+1.
- Accumulation never overflows within legal parameters, because ACC_WIDTH >= DATA_WIDTH+SRC_WIDTH.
- Reset asserted in any state returns to reset values on the next clock edge and aborts the round. No partial writeback completes.

Test Plan:
- rank_no=4, num_src=2; beats (addr,data) (0,10),(1,20),(2,30),(3,40),(0,1),(1,2),(2,3),(3,4), back-to-back -> writes 11,22,33,44 to addr 0..3 on four consecutive cycles starting one cycle after the last beat. fin_accum on the addr-3 write; err_addr=0.
- Saturation: rank_no=1, num_src=3, three beats (0,20000) -> single write 32767. Repeat with -20000 -> -32768.
- Bad address: rank_no=2, num_src=1, beats (3,5) then (0,7) -> err_addr=1; writes addr0=7, addr1=0; fin_accum asserted. A following start clears err_addr.
- Degenerate: start with num_src=0 -> fin_accum high exactly one cycle later; busy stays 0; no act_write_en.
- Reset mid-COLLECT after beats (0,100),(1,50) of a rank_no=2, num_src=2 round -> busy=0. A new round rank_no=2, num_src=1 with beats (0,1),(1,2) writes 1,2; no stale sums appear.
- Protocol robustness: recv_en held high during WRITEBACK and start pulsed during COLLECT -> no recv_rdy, totals unchanged, round length unaffected.
